// File: rtl/uart_tx_frame_engine.sv
// UART transmit framer: synchronises the divided baud clock into clk_in,
// turns its rising edges into one-cycle ticks and serialises start/data/parity/stop bits.
module uart_tx_frame_engine #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic                 sync0, sync1, prev, baud_tick;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [CW-1:0]        bit_cnt, bit_cnt_nx;
    logic                 stop_cnt, stop_cnt_nx;   // at most two stop bits
    logic                 par_en, par_en_nx, par_bit, par_bit_nx;
    logic                 tx_nx, busy_nx, done_nx;

    // baud_clk is asynchronous data: two-flop synchroniser, then rising-edge detect
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync0 <= baud_clk;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    assign baud_tick = sync1 & ~prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            bit_cnt  <= bit_cnt_nx;
            stop_cnt <= stop_cnt_nx;
            par_en   <= par_en_nx;
            par_bit  <= par_bit_nx;
            tx       <= tx_nx;
            tx_busy  <= busy_nx;
            tx_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        bit_cnt_nx  = bit_cnt;
        stop_cnt_nx = stop_cnt;
        par_en_nx   = par_en;
        par_bit_nx  = par_bit;
        tx_nx       = tx;
        busy_nx     = tx_busy;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                if (tx_start) begin
                    shift_nx   = tx_data;
                    par_en_nx  = parity_en;
                    par_bit_nx = ^tx_data ^ parity_odd;
                    busy_nx    = 1'b1;
                    state_nx   = ALIGN;
                end
            end
            // wait for a tick so the start bit spans a whole baud period
            ALIGN: if (baud_tick) begin
                tx_nx    = 1'b0;
                state_nx = START;
            end
            START: if (baud_tick) begin
                tx_nx      = shift[0];
                shift_nx   = shift >> 1;
                bit_cnt_nx = '0;
                state_nx   = DATA;
            end
            DATA: if (baud_tick) begin
                if (bit_cnt == CW'(DATA_BITS - 1)) begin
                    if (par_en) begin
                        tx_nx    = par_bit;
                        state_nx = PARITY;
                    end else begin
                        tx_nx       = 1'b1;
                        stop_cnt_nx = 1'b0;
                        state_nx    = STOP;
                    end
                end else begin
                    tx_nx      = shift[0];
                    shift_nx   = shift >> 1;
                    bit_cnt_nx = bit_cnt + CW'(1);
                end
            end
            PARITY: if (baud_tick) begin
                tx_nx       = 1'b1;
                stop_cnt_nx = 1'b0;
                state_nx    = STOP;
            end
            STOP: if (baud_tick) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    stop_cnt_nx = stop_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: one- and two-stop-bit instances share stimulus; expected
// frames come from a bit-list model and are compared at every baud tick.
module tb_uart_tx_frame_engine;
    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       baud_clk = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       tx1, busy1, done1, tx2, busy2, done2;
    logic       tx_m, busy_m, done_m;
    logic       sel = 1'b0;
    logic       freeze = 1'b0;
    int         half_per = 10;
    int         gen_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt1 = 0;
    int         done_cnt2 = 0;
    logic       exp_tx[$];
    logic       exp_done[$];

    uart_tx_frame_engine #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .clk_in(clk_in), .reset(reset), .baud_clk(baud_clk), .tx_start(tx_start),
        .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx1), .tx_busy(busy1), .tx_done(done1));

    uart_tx_frame_engine #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk_in(clk_in), .reset(reset), .baud_clk(baud_clk), .tx_start(tx_start),
        .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx2), .tx_busy(busy2), .tx_done(done2));

    assign tx_m   = sel ? tx2 : tx1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;

    initial forever #5 clk_in = ~clk_in;

    // divided baud clock, changed on falling clk_in edges; freeze holds its level
    initial forever begin
        @(negedge clk_in);
        if (!freeze) begin
            gen_cnt++;
            if (gen_cnt >= half_per) begin
                gen_cnt  = 0;
                baud_clk = ~baud_clk;
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (done1 === 1'b1) done_cnt1++;
        if (done2 === 1'b1) done_cnt2++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // tx level after each baud tick: start, LSB-first data, parity, stop ones, then the done tick
    function automatic void push_frame(input logic [7:0] d, input bit pen, input bit podd, input int sb);
        exp_tx.push_back(1'b0); exp_done.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_tx.push_back(d[i]); exp_done.push_back(1'b0);
        end
        if (pen) begin
            exp_tx.push_back((($countones(d) % 2) == 1) ? ~podd : podd);
            exp_done.push_back(1'b0);
        end
        for (int i = 0; i < sb; i++) begin
            exp_tx.push_back(1'b1); exp_done.push_back(1'b0);
        end
        exp_tx.push_back(1'b1); exp_done.push_back(1'b1);
    endfunction

    task automatic run_stream(input string name, input bit hold, input bit noise, input int freeze_at,
                              input int abort_at, input int rate_at, input int nframes, input logic [7:0] data2);
        int   n, d0;
        logic prev_tx;
        n       = exp_tx.size();
        prev_tx = 1'b1;
        d0      = sel ? done_cnt2 : done_cnt1;
        for (int k = 0; k < n; k++) begin
            @(posedge baud_clk);
            if (k == 0) tx_start = 1'b1;
            @(posedge clk_in); @(negedge clk_in);
            if (k == 0 && !hold) tx_start = 1'b0;
            @(posedge clk_in); @(negedge clk_in);
            checks++;
            if (tx_m !== prev_tx) begin
                errors++;
                $display("FAIL %s early_tx k=%0d got=%b want=%b", name, k, tx_m, prev_tx);
            end
            @(posedge clk_in); @(negedge clk_in);
            checks++;
            if (tx_m !== exp_tx[k]) begin
                errors++;
                $display("FAIL %s tx_bit k=%0d got=%b want=%b", name, k, tx_m, exp_tx[k]);
            end
            checks++;
            if (done_m !== exp_done[k]) begin
                errors++;
                $display("FAIL %s tx_done k=%0d got=%b want=%b", name, k, done_m, exp_done[k]);
            end
            checks++;
            if (busy_m !== !exp_done[k]) begin
                errors++;
                $display("FAIL %s tx_busy k=%0d got=%b want=%b", name, k, busy_m, !exp_done[k]);
            end
            prev_tx = exp_tx[k];
            if (!hold && k == 1) begin
                tx_data    = 8'($urandom);
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
            end
            if (hold && k == 3) tx_data = data2;
            if (hold && k == n - 2) tx_start = 1'b0;
            if (k == rate_at) half_per = $urandom_range(6, 14);
            if (k == freeze_at) begin
                freeze = 1'b1;
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk_in);
                    checks++;
                    if (tx_m !== exp_tx[k] || busy_m !== 1'b1 || done_m !== 1'b0) begin
                        errors++;
                        $display("FAIL %s freeze_hold cyc=%0d got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                                 name, c, tx_m, busy_m, done_m, exp_tx[k]);
                    end
                end
                freeze = 1'b0;
            end
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                checks++;
                if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset got tx=%b busy=%b done=%b want tx=1 busy=0 done=0",
                             name, tx_m, busy_m, done_m);
                end
                repeat (3) @(negedge clk_in);
                reset = 1'b0;
                repeat (60) begin
                    @(negedge clk_in);
                    checks++;
                    if (tx_m !== 1'b1 || busy_m !== 1'b0) begin
                        errors++;
                        $display("FAIL %s post_reset_idle got tx=%b busy=%b want tx=1 busy=0", name, tx_m, busy_m);
                    end
                end
                checks++;
                if ((sel ? done_cnt2 : done_cnt1) != d0) begin
                    errors++;
                    $display("FAIL %s abort_done_count got=%0d want=%0d", name, sel ? done_cnt2 : done_cnt1, d0);
                end
                exp_tx.delete(); exp_done.delete();
                half_per = 10;
                return;
            end
            if (noise && k < n - 2) begin
                tx_data  = 8'($urandom);
                tx_start = 1'b1;
                @(negedge clk_in);
                tx_start = 1'b0;
            end
        end
        repeat (60) begin
            @(negedge clk_in);
            checks++;
            if (tx_m !== 1'b1 || busy_m !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after got tx=%b busy=%b want tx=1 busy=0", name, tx_m, busy_m);
            end
        end
        checks++;
        if ((sel ? done_cnt2 : done_cnt1) - d0 != nframes) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d want=%0d", name, (sel ? done_cnt2 : done_cnt1) - d0, nframes);
        end
        exp_tx.delete(); exp_done.delete();
        half_per = 10;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got tx=%b/%b busy=%b/%b done=%b want tx=1 busy=0 done=0",
                     tx1, tx2, busy1, busy2, done1);
        end
        reset = 1'b0;
        repeat (60) begin
            @(negedge clk_in);
            checks++;
            if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got tx=%b busy=%b want tx=1 busy=0", tx1, busy1);
            end
        end
        checks++;
        if (done_cnt1 != 0 || done_cnt2 != 0) begin
            errors++;
            $display("FAIL reset_no_done got=%0d/%0d want=0", done_cnt1, done_cnt2);
        end
    endtask

    task automatic test_basic_a5();
        sel = 1'b0; tx_data = 8'hA5; parity_en = 1'b0; parity_odd = 1'b0;
        push_frame(8'hA5, 1'b0, 1'b0, 1);
        run_stream("frame_a5", 1'b0, 1'b0, -1, -1, -1, 1, 8'h00);
    endtask

    task automatic test_parity();
        for (int p = 0; p < 2; p++) begin
            sel = 1'b0; tx_data = 8'h03; parity_en = 1'b1; parity_odd = 1'(p);
            push_frame(8'h03, 1'b1, 1'(p), 1);
            run_stream(p ? "parity_odd" : "parity_even", 1'b0, 1'b0, -1, -1, -1, 1, 8'h00);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pe, po;
        for (int i = 0; i < 5; i++) begin
            sel = (i >= 3);
            d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom);
            tx_data = d; parity_en = pe; parity_odd = po;
            push_frame(d, pe, po, sel ? 2 : 1);
            run_stream(sel ? "random_rate" : "random_noise", 1'b0, !sel, -1, -1, sel ? 3 : -1, 1, 8'h00);
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0;
        push_frame(8'h55, 1'b0, 1'b0, 1);
        push_frame(8'hF0, 1'b0, 1'b0, 1);
        run_stream("back_to_back", 1'b1, 1'b0, -1, -1, -1, 2, 8'hF0);
    endtask

    task automatic test_abort();
        logic [7:0] d;
        sel = 1'b0; tx_data = 8'hFF; parity_en = 1'b0; parity_odd = 1'b0;
        push_frame(8'hFF, 1'b0, 1'b0, 1);
        run_stream("abort", 1'b0, 1'b0, -1, 5, -1, 0, 8'h00);
        d = 8'($urandom);
        tx_data = d; parity_en = 1'b1; parity_odd = 1'b1;
        push_frame(d, 1'b1, 1'b1, 1);
        run_stream("after_abort", 1'b0, 1'b0, -1, -1, -1, 1, 8'h00);
    endtask

    task automatic test_stop2_freeze();
        logic [7:0] d;
        sel = 1'b1;
        d = 8'($urandom);
        tx_data = d; parity_en = 1'b0; parity_odd = 1'b0;
        push_frame(d, 1'b0, 1'b0, 2);
        run_stream("stop2_freeze", 1'b0, 1'b0, 4, -1, -1, 1, 8'h00);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_parity();
        test_random();
        test_back_to_back();
        test_abort();
        test_stop2_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_engine.md
Name: uart_tx_frame_engine

Overview:
- UART transmit stage directly downstream of the transmitter baud-rate selector.
- Consumes the selector's divided baud clock as a level signal, synchronises it into the system clock domain and converts each rising edge into a one-cycle baud tick.
- Serialises a parallel word into a standard UART frame: start bit, LSB-first data, optional parity, stop bit(s).
- Uses a ready/busy/done handshake toward the upstream controller.

Parameters:
- DATA_BITS, 8, data bits per frame (legal 5..8).
- STOP_BITS, 1, stop bits per frame (legal 1..2).

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- baud_clk  input  1  divided baud clock from the baud-rate selector; treated as asynchronous data, never used as a clock.
- tx_start  input  1  request to send; sampled every clk_in cycle.
- tx_data  input  DATA_BITS  word to send; sampled only on acceptance.
- parity_en  input  1  1 = insert parity bit; sampled on acceptance.
- parity_odd  input  1  1 = odd parity, 0 = even; sampled on acceptance.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high from acceptance until return to IDLE.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, tx_busy=0, tx_done=0.
  - State=IDLE.
  - Synchroniser flops and edge-detect flop =0.
  - Shift register, bit counter and stop counter =0.
- Tick generation:
  - sync0 <= baud_clk; sync1 <= sync0; prev <= sync1.
  - baud_tick = sync1 & ~prev.
  - A baud_clk rise sampled at edge N gives baud_tick high for exactly the cycle after edge N+1.
  - tx updates at edge N+2.
  - Falling edges generate nothing.
- FSM states: IDLE, ALIGN, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - On tx_start=1, latch tx_data, parity_en and parity_odd.
  - Compute parity = ^tx_data ^ parity_odd.
  - Set tx_busy=1 on the next edge and go to ALIGN.
- ALIGN:
  - tx stays 1 until the first baud_tick.
  - On that tick: tx<=0, go to START.
  - This guarantees every bit lasts a full baud period.
- START:
  - On baud_tick: tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
- DATA:
  - On baud_tick with bit_cnt<DATA_BITS-1: tx<=next bit, bit_cnt++.
  - On baud_tick with bit_cnt=DATA_BITS-1:
    - If parity_en latched: tx<=parity, go to PARITY.
    - Otherwise: tx<=1, stop_cnt<=0, go to STOP.
- PARITY:
  - On baud_tick: tx<=1, stop_cnt<=0, go to STOP.
- STOP:
  - On baud_tick with stop_cnt<STOP_BITS-1: stop_cnt++.
  - On baud_tick with stop_cnt=STOP_BITS-1: go to IDLE, tx_busy<=0, tx_done<=1 for one cycle.
- Outside tick cycles no state, counter or tx change occurs.
- Handshake and boundary rules:
  - tx_start is ignored while tx_busy=1; no queuing.
  - tx_start held high in IDLE is accepted once per frame. A new frame starts in the cycle after tx_done, since state is IDLE when tx_done is high.
  - tx_start high in the same cycle as tx_done is accepted.
  - tx_data and parity inputs may change freely after acceptance without affecting the frame in flight.
  - If baud_clk stops toggling, the FSM holds its current state and tx level indefinitely. No timeout.
  - If the upstream selector changes rate mid-frame, the remaining bits take the new period. No error flag.
  - Reset asserted mid-frame forces tx=1 asynchronously and abandons the frame. No tx_done is produced.
  - Transmission resumes only after reset deasserts and a fresh tx_start is received.
- Frame length in ticks after ALIGN = 1 + DATA_BITS + parity_en + STOP_BITS.

Test Plan:
- Reset then idle, with baud_clk toggling every 10 clk_in cycles → tx=1, tx_busy=0, tx_done never pulses.
- tx_data=8'hA5, parity_en=0, one tx_start pulse → tx sequence per tick 0,1,0,1,0,0,1,0,1,1. Each bit lasts 20 clk_in cycles. One tx_done pulse aligned with the end of the stop bit.
- tx_data=8'h03, parity_en=1, parity_odd=0 → parity bit 0. Repeat with parity_odd=1 → parity bit 1. Frame is 11 bits.
- tx_start held high continuously, with tx_data=8'h55 then 8'hF0 changed mid-frame → exactly two back-to-back frames, the second carrying the value present at its acceptance. tx_start pulses during busy have no effect.
- Reset asserted during data bit 4 of 8'hFF → tx=1 in the same cycle (asynchronous), tx_busy=0, no tx_done. The next tx_start sends a complete, correct frame.
- STOP_BITS=2 with baud_clk frozen high for 100 cycles mid-DATA → FSM holds state and tx level. On resumption the frame completes with 2 stop ticks before tx_done.
